masked_monomial_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-bit masked-monomial generator used in the two-stage AES S-box.
- For an N_IN-bit unmasked input it produces all 2^N_IN-1 non-constant monomials (AND products of input-bit subsets), each XOR-masked with one fresh random bit.
- Sits between the first-stage share logic and the second-stage S-box recombination.
- Adds register stages as glitch barriers, valid/ready handshakes on data, randomness and output, synchronous flush, and an operation counter.

---
 rtl/masked_monomial_pipe.sv | 129 ++++++++++++
 tb/tb_masked_monomial_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_monomial_pipe.sv
// rtl/masked_monomial_pipe.sv - pipelined generator of masked AND-monomials of an N_IN-bit input
module masked_monomial_pipe #(
    parameter int N_IN        = 4,
    parameter int PIPE_STAGES = 2,
    parameter int CNT_W       = 16,
    localparam int M          = (1 << N_IN) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  inp,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [M-1:0]     rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out,
    output logic [CNT_W-1:0] op_count
);

    // Widths beyond 6 would make the monomial vector impractically wide.
    if (N_IN < 2 || N_IN > 6) begin : g_bad_n_in
        $fatal(1, "masked_monomial_pipe: N_IN must be in 2..6");
    end

    // Bit k-1 is the AND of the input bits selected by k, masked by rnd[k-1].
    function automatic logic [M-1:0] monomials(input logic [N_IN-1:0] x,
                                               input logic [M-1:0]    r);
        logic [M-1:0]    m;
        logic [N_IN-1:0] sel;
        m = '0;
        for (int k = 1; k <= M; k++) begin
            sel      = N_IN'(k);
            m[k-1]   = (&(x | ~sel)) ^ r[k-1];
        end
        return m;
    endfunction

    logic             out_valid_q;
    logic [M-1:0]     out_q;
    logic [CNT_W-1:0] op_count_q;
    logic             last_load;
    logic             accept;

    // The output stage may take a new item whenever it is empty or being drained.
    assign last_load = !out_valid_q | out_ready;
    // Randomness is only ever consumed together with data.
    assign accept    = in_valid & rnd_valid & in_ready;
    assign rnd_ready = accept;

    if (PIPE_STAGES == 1) begin : g_one_stage
        // Reset and flush both keep the block from accepting.
        assign in_ready = rst_n & !flush & last_load;

        // Output register: monomials computed straight from the ports.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_q       <= '0;
            end else if (flush) begin
                out_valid_q <= 1'b0;
            end else if (last_load) begin
                out_valid_q <= accept;
                if (accept) begin
                    out_q <= monomials(inp, rnd);
                end
            end
        end
    end else if (PIPE_STAGES == 2) begin : g_two_stage
        logic            s1_valid;
        logic [N_IN-1:0] s1_inp;
        logic [M-1:0]    s1_rnd;
        logic            s1_load;

        // Stage 1 can take an item if it is empty or its contents move on now.
        assign s1_load  = !s1_valid | last_load;
        assign in_ready = rst_n & !flush & s1_load;

        // Stage 1: register raw input and mask bits as a glitch barrier.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_inp   <= '0;
                s1_rnd   <= '0;
            end else if (flush) begin
                s1_valid <= 1'b0;
            end else if (s1_load) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_inp <= inp;
                    s1_rnd <= rnd;
                end
            end
        end

        // Stage 2: compute monomials from stage 1 and hold them for the consumer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_q       <= '0;
            end else if (flush) begin
                out_valid_q <= 1'b0;
            end else if (last_load) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_q <= monomials(s1_inp, s1_rnd);
                end
            end
        end
    end else begin : g_bad_stages
        $fatal(1, "masked_monomial_pipe: PIPE_STAGES must be 1 or 2");
    end

    // Count completed output transfers; a transfer coinciding with flush still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (out_valid_q && out_ready) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_masked_monomial_pipe.sv
// tb/tb_masked_monomial_pipe.sv - directed self-checking bench for masked_monomial_pipe
module tb_masked_monomial_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic rnd_valid = 1'b0;
    logic out_ready = 1'b0;

    logic [3:0]  inp4 = '0;
    logic [14:0] rnd4 = '0;
    logic [1:0]  inp2 = '0;
    logic [2:0]  rnd2 = '0;
    logic [5:0]  inp6 = '0;
    logic [62:0] rnd6 = '0;

    logic        in_ready0, rnd_ready0, out_valid0;
    logic [14:0] out0;
    logic [15:0] cnt0;
    logic        in_ready1, rnd_ready1, out_valid1;
    logic [14:0] out1;
    logic [3:0]  cnt1;
    logic        in_ready2, rnd_ready2, out_valid2;
    logic [2:0]  out2;
    logic [15:0] cnt2;
    logic        in_ready3, rnd_ready3, out_valid3;
    logic [62:0] out3;
    logic [15:0] cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    masked_monomial_pipe #(.N_IN(4), .PIPE_STAGES(2), .CNT_W(16)) d0 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .inp(inp4),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready0), .rnd(rnd4),
        .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .op_count(cnt0));

    masked_monomial_pipe #(.N_IN(4), .PIPE_STAGES(1), .CNT_W(4)) d1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .inp(inp4),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready1), .rnd(rnd4),
        .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .op_count(cnt1));

    masked_monomial_pipe #(.N_IN(2), .PIPE_STAGES(2), .CNT_W(16)) d2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .inp(inp2),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready2), .rnd(rnd2),
        .out_valid(out_valid2), .out_ready(out_ready), .out(out2), .op_count(cnt2));

    masked_monomial_pipe #(.N_IN(6), .PIPE_STAGES(1), .CNT_W(16)) d3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready3), .inp(inp6),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready3), .rnd(rnd6),
        .out_valid(out_valid3), .out_ready(out_ready), .out(out3), .op_count(cnt3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        #3;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
        checks++; if (out0 !== 15'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", out0); end
        checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", cnt0); end
        checks++; if (in_ready0 !== 1'b0 || rnd_ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", in_ready0, rnd_ready0); end
        checks++; if (in_ready1 !== 1'b0 || out1 !== 15'h0 || cnt1 !== 4'd0) begin errors++; $display("FAIL reset_ps1 got=%b/%h/%0d exp=0/0/0", in_ready1, out1, cnt1); end
        @(posedge clk);
        in_valid = 1'b0; rnd_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b1 || in_ready1 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b%b exp=11", in_ready0, in_ready1); end
    endtask

    task automatic test_single();
        tick();
        inp4 = 4'hF; rnd4 = '0; inp2 = 2'b11; rnd2 = '0; inp6 = 6'h3F; rnd6 = '0;
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++; if (rnd_ready0 !== 1'b1) begin errors++; $display("FAIL single_rnd_ready got=%b exp=1", rnd_ready0); end
        tick();
        in_valid = 1'b0; rnd_valid = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL single_latency1_ps2 got=%b exp=0", out_valid0); end
        checks++; if (out_valid1 !== 1'b1 || out1 !== 15'h7FFF) begin errors++; $display("FAIL single_ps1 got=%b/%h exp=1/7fff", out_valid1, out1); end
        checks++; if (out_valid3 !== 1'b1 || out3 !== 63'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL single_n6 got=%b/%h exp=1/all-ones", out_valid3, out3); end
        tick();
        checks++; if (out_valid0 !== 1'b1 || out0 !== 15'h7FFF) begin errors++; $display("FAIL single_ps2 got=%b/%h exp=1/7fff", out_valid0, out0); end
        checks++; if (out_valid2 !== 1'b1 || out2 !== 3'b111) begin errors++; $display("FAIL single_n2 got=%b/%b exp=1/111", out_valid2, out2); end
        checks++; if (cnt0 !== 16'd0 || cnt1 !== 4'd1) begin errors++; $display("FAIL single_cnt_mid got=%0d/%0d exp=0/1", cnt0, cnt1); end
        tick();
        checks++; if (out_valid0 !== 1'b0 || cnt0 !== 16'd1) begin errors++; $display("FAIL single_cnt got=%b/%0d exp=0/1", out_valid0, cnt0); end
    endtask

    task automatic test_patterns();
        tick();
        inp4 = 4'b0101; rnd4 = 15'h0000; inp2 = 2'b10; rnd2 = 3'b000; inp6 = 6'b000001; rnd6 = '0;
        in_valid = 1'b1; rnd_valid = 1'b1;
        #1;
        tick();
        inp4 = 4'b0101; rnd4 = 15'h7FFF; inp2 = 2'b10; rnd2 = 3'b111; inp6 = 6'b000011; rnd6 = '0;
        #1;
        checks++; if (out1 !== 15'h0019) begin errors++; $display("FAIL pat_ps1_a got=%h exp=0019", out1); end
        checks++; if (out3 !== 63'h1) begin errors++; $display("FAIL pat_n6_a got=%h exp=1", out3); end
        tick();
        in_valid = 1'b0; rnd_valid = 1'b0;
        #1;
        checks++; if (out0 !== 15'h0019) begin errors++; $display("FAIL pat_ps2_a got=%h exp=0019", out0); end
        checks++; if (out1 !== 15'h7FE6) begin errors++; $display("FAIL pat_ps1_b got=%h exp=7fe6", out1); end
        checks++; if (out2 !== 3'b010) begin errors++; $display("FAIL pat_n2_a got=%b exp=010", out2); end
        checks++; if (out3 !== 63'h7) begin errors++; $display("FAIL pat_n6_b got=%h exp=7", out3); end
        tick();
        checks++; if (out0 !== 15'h7FE6) begin errors++; $display("FAIL pat_ps2_b got=%h exp=7fe6", out0); end
        checks++; if (out2 !== 3'b101) begin errors++; $display("FAIL pat_n2_b got=%b exp=101", out2); end
        tick();
        checks++; if (cnt0 !== 16'd3 || cnt1 !== 4'd3) begin errors++; $display("FAIL pat_cnt got=%0d/%0d exp=3/3", cnt0, cnt1); end
    endtask

    task automatic test_rnd_stall();
        int n;
        n = 0;
        tick();
        inp4 = 4'b0011; rnd4 = '0; in_valid = 1'b1; rnd_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rnd_ready0 !== 1'b0) begin errors++; $display("FAIL stall_rnd_ready got=%b exp=0", rnd_ready0); end
            tick();
        end
        checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL stall_no_out got=%b%b exp=00", out_valid0, out_valid1); end
        rnd_valid = 1'b1;
        #1;
        checks++; if (rnd_ready0 !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", rnd_ready0); end
        tick();
        in_valid = 1'b0; rnd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_valid0 && out_ready) begin
                n++;
                checks++; if (out0 !== 15'h0007) begin errors++; $display("FAIL stall_data got=%h exp=0007", out0); end
            end
            tick();
        end
        checks++; if (n !== 1) begin errors++; $display("FAIL stall_single_accept got=%0d exp=1", n); end
        checks++; if (cnt0 !== 16'd4) begin errors++; $display("FAIL stall_cnt got=%0d exp=4", cnt0); end
    endtask

    task automatic test_back_to_back();
        logic [14:0] tbl [8];
        logic [14:0] held;
        logic [14:0] expv;
        int in_idx, out_idx, stall;
        bit prev_stalled, saw_full;
        tbl = '{15'h0000, 15'h0001, 15'h0002, 15'h0007, 15'h0008, 15'h0019, 15'h002A, 15'h007F};
        in_idx = 0; out_idx = 0; stall = 0; prev_stalled = 1'b0; saw_full = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && out_idx < 8; cyc++) begin
            in_valid = (in_idx < 8); rnd_valid = (in_idx < 8);
            inp4 = 4'(in_idx); rnd4 = 15'(in_idx) << 8;
            out_ready = (stall == 0);
            #1;
            if (out_valid0 && !out_ready && prev_stalled) begin
                checks++; if (out0 !== held) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", out0, held); end
            end
            if (in_valid && !in_ready0 && out_valid0 && !out_ready) saw_full = 1'b1;
            if (stall > 0 && !out_ready) stall--;
            if (out_valid0 && out_ready) begin
                expv = tbl[out_idx] ^ (15'(out_idx) << 8);
                checks++; if (out0 !== expv) begin errors++; $display("FAIL b2b_item%0d got=%h exp=%h", out_idx, out0, expv); end
                out_idx++;
                if (out_idx == 1) stall = 4;
            end
            prev_stalled = out_valid0 && !out_ready;
            if (rnd_ready0) in_idx++;
            held = out0;
            tick();
        end
        in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_idx !== 8) begin errors++; $display("FAIL b2b_delivered got=%0d exp=8", out_idx); end
        checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_low got=%b exp=1", saw_full); end
        checks++; if (cnt0 !== 16'd12) begin errors++; $display("FAIL b2b_cnt got=%0d exp=12", cnt0); end
    endtask

    task automatic test_flush();
        tick();
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b0; inp4 = 4'h7; rnd4 = '0;
        #1;
        tick();
        inp4 = 4'h1;
        #1;
        tick();
        flush = 1'b1;
        #1;
        checks++; if (in_ready0 !== 1'b0 || rnd_ready0 !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b%b exp=00", in_ready0, rnd_ready0); end
        checks++; if (out_valid0 !== 1'b1 || out0 !== 15'h007F) begin errors++; $display("FAIL flush_pre got=%b/%h exp=1/007f", out_valid0, out0); end
        tick();
        flush = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid0); end
        checks++; if (cnt0 !== 16'd12 || out0 !== 15'h007F) begin errors++; $display("FAIL flush_keep got=%0d/%h exp=12/007f", cnt0, out0); end
        tick();
        tick();
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL flush_s1_cleared got=%b exp=0", out_valid0); end
        in_valid = 1'b1; rnd_valid = 1'b1; inp4 = 4'h1; out_ready = 1'b1;
        #1;
        tick();
        in_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        tick();
        flush = 1'b0;
        #1;
        checks++; if (cnt0 !== 16'd13 || out_valid0 !== 1'b0) begin errors++; $display("FAIL flush_transfer_counts got=%0d/%b exp=13/0", cnt0, out_valid0); end
    endtask

    task automatic test_reset_mid();
        tick();
        out_ready = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; inp4 = 4'hF; rnd4 = '0;
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid0 !== 1'b0 || out0 !== 15'h0 || cnt0 !== 16'd0) begin errors++; $display("FAIL rst_mid_ps2 got=%b/%h/%0d exp=0/0/0", out_valid0, out0, cnt0); end
        checks++; if (out_valid1 !== 1'b0 || out1 !== 15'h0 || cnt1 !== 4'd0) begin errors++; $display("FAIL rst_mid_ps1 got=%b/%h/%0d exp=0/0/0", out_valid1, out1, cnt1); end
        in_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_wrap();
        int miss;
        miss = 0;
        tick();
        out_ready = 1'b1; in_valid = 1'b1; rnd_valid = 1'b1; inp4 = 4'h3; rnd4 = '0;
        for (int i = 0; i < 17; i++) begin
            #1;
            if (!rnd_ready1 || !rnd_ready0) miss++;
            tick();
        end
        in_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (miss !== 0) begin errors++; $display("FAIL wrap_accepts got=%0d exp=0 misses", miss); end
        checks++; if (cnt1 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got=%0d exp=1", cnt1); end
        checks++; if (cnt0 !== 16'd17 || cnt2 !== 16'd17 || cnt3 !== 16'd17) begin errors++; $display("FAIL wrap_cnt16 got=%0d/%0d/%0d exp=17", cnt0, cnt2, cnt3); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_rnd_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
